// File: rtl/sbox_layer_sched_pkg.sv
// Shared types and constants for the PRESENT S-layer scheduler.
// Holds FSM encodings, nibble count and counter helpers.
package sbox_layer_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam int NIBBLES      = 16;
  localparam int SBOX_LAT_DEF = 4;
  localparam int CNT_W        = 5;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NIBBLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == CNT_MAX) ? CNT_MAX : v + 1'b1;
  endfunction

endpackage

// File: rtl/sbox_layer_sched_shreg.sv
// One share of state: 64-bit load / shift-right-by-4 register.
// The insert nibble enters at [63:60] on every shift.
module share_nibble_shreg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        shift,
  input  logic [63:0] load_val,
  input  logic [3:0]  ins,
  output logic [63:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= {ins, q[63:4]};
    end
  end

endmodule

// File: rtl/sbox_layer_sched.sv
// Feeds the 16 nibbles of a 3-share state through a shared masked S-box
// pipeline and reassembles the substituted shares.
module sbox_layer_sched
  import sbox_layer_sched_pkg::*;
#(
  parameter int SBOX_LAT = SBOX_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] state_in1,
  input  logic [63:0] state_in2,
  input  logic [63:0] state_in3,
  output logic        busy,
  output logic        done,
  output logic [63:0] state_out1,
  output logic [63:0] state_out2,
  output logic [63:0] state_out3,
  output logic [3:0]  sbox_in1,
  output logic [3:0]  sbox_in2,
  output logic [3:0]  sbox_in3,
  output logic        sbox_en,
  input  logic [3:0]  sbox_out1,
  input  logic [3:0]  sbox_out2,
  input  logic [3:0]  sbox_out3
);

  state_e state_q, state_d;

  logic [CNT_W-1:0]    issue_cnt;
  logic [CNT_W-1:0]    ret_cnt;
  logic [SBOX_LAT-1:0] vld_q;
  logic [SBOX_LAT-1:0] vld_d;
  logic [SBOX_LAT-1:0] vld_mid;

  logic accept;
  logic issue;
  logic cap;
  logic last_cap;
  logic unused_bits;

  logic [63:0] st_in  [3];
  logic [3:0]  sb_out [3];
  logic [3:0]  sb_in  [3];
  logic [63:0] in_q   [3];
  logic [63:0] out_q  [3];
  logic [63:0] res_q  [3];

  assign st_in[0]  = state_in1;
  assign st_in[1]  = state_in2;
  assign st_in[2]  = state_in3;
  assign sb_out[0] = sbox_out1;
  assign sb_out[1] = sbox_out2;
  assign sb_out[2] = sbox_out3;

  assign accept   = (state_q == S_IDLE) && start;
  assign issue    = (state_q == S_ISSUE);
  assign cap      = vld_q[SBOX_LAT-1];
  assign last_cap = cap && (ret_cnt == CNT_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: if (issue_cnt == CNT_LAST) state_d = S_DRAIN;
      S_DRAIN: begin
        if (last_cap || ret_cnt == CNT_MAX) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The top tap is the capture strobe itself; the nibble there has
  // already left the pipeline, so it does not keep the enable high.
  always_comb begin
    vld_d                = vld_q << 1;
    vld_d[0]             = issue;
    vld_mid              = vld_q;
    vld_mid[SBOX_LAT-1]  = 1'b0;
  end

  assign sbox_en = issue | (|vld_mid);
  assign busy    = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done    = (state_q == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      vld_q     <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      if (accept) begin
        issue_cnt <= '0;
        ret_cnt   <= '0;
      end else begin
        if (issue) issue_cnt <= sat_inc(issue_cnt);
        if (cap)   ret_cnt   <= sat_inc(ret_cnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) res_q[k] <= '0;
    end else if (last_cap) begin
      for (int k = 0; k < 3; k++) begin
        res_q[k] <= {sb_out[k], out_q[k][63:4]};
      end
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_share
    share_nibble_shreg u_in (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept),
      .shift    (issue),
      .load_val (st_in[k]),
      .ins      (4'h0),
      .q        (in_q[k])
    );

    share_nibble_shreg u_out (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept),
      .shift    (cap),
      .load_val (64'h0),
      .ins      (sb_out[k]),
      .q        (out_q[k])
    );

    assign sb_in[k] = issue ? in_q[k][3:0] : 4'h0;
  end

  assign sbox_in1   = sb_in[0];
  assign sbox_in2   = sb_in[1];
  assign sbox_in3   = sb_in[2];
  assign state_out1 = res_q[0];
  assign state_out2 = res_q[1];
  assign state_out3 = res_q[2];

  assign unused_bits = ^{in_q[0][63:4], in_q[1][63:4], in_q[2][63:4],
                         out_q[0][3:0], out_q[1][3:0], out_q[2][3:0]};

endmodule

// File: tb/tb_sbox_layer_sched.sv
// Bench for sbox_layer_sched: two instances (SBOX_LAT 4 and 1), each
// driving a behavioural 3-share S-box pipeline, checked against a model.
module tb_sbox_layer_sched;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start [2];
  logic [63:0] si1 [2], si2 [2], si3 [2];
  logic [63:0] so1 [2], so2 [2], so3 [2];
  logic        busy [2], done [2], en [2];
  logic [3:0]  bi1 [2], bi2 [2], bi3 [2];
  logic [3:0]  bo1 [2], bo2 [2], bo3 [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_abs = 0;

  always @(posedge clk) cyc_abs <= cyc_abs + 1;

  sbox_layer_sched #(.SBOX_LAT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start[0]),
    .state_in1(si1[0]), .state_in2(si2[0]), .state_in3(si3[0]),
    .busy(busy[0]), .done(done[0]),
    .state_out1(so1[0]), .state_out2(so2[0]), .state_out3(so3[0]),
    .sbox_in1(bi1[0]), .sbox_in2(bi2[0]), .sbox_in3(bi3[0]),
    .sbox_en(en[0]),
    .sbox_out1(bo1[0]), .sbox_out2(bo2[0]), .sbox_out3(bo3[0])
  );

  sbox_layer_sched #(.SBOX_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]),
    .state_in1(si1[1]), .state_in2(si2[1]), .state_in3(si3[1]),
    .busy(busy[1]), .done(done[1]),
    .state_out1(so1[1]), .state_out2(so2[1]), .state_out3(so3[1]),
    .sbox_in1(bi1[1]), .sbox_in2(bi2[1]), .sbox_in3(bi3[1]),
    .sbox_en(en[1]),
    .sbox_out1(bo1[1]), .sbox_out2(bo2[1]), .sbox_out3(bo3[1])
  );

  function automatic logic [3:0] sb(input logic [3:0] x);
    logic [63:0] t;
    t = 64'hC56B90AD3EF84712;
    return t[(15 - int'(x)) * 4 +: 4];
  endfunction

  function automatic logic [63:0] slayer(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = sb(x[4*i +: 4]);
    return r;
  endfunction

  // Deterministic shared S-box: output shares XOR to S(in1^in2^in3).
  function automatic logic [11:0] ext_sbox(
    input logic [3:0] a, input logic [3:0] b, input logic [3:0] c
  );
    return {a, b, sb(a ^ b ^ c) ^ a ^ b};
  endfunction

  logic [11:0] p4 [4];
  logic [11:0] p1;

  always @(posedge clk) begin
    if (en[0]) begin
      p4[0] <= ext_sbox(bi1[0], bi2[0], bi3[0]);
      p4[1] <= p4[0];
      p4[2] <= p4[1];
      p4[3] <= p4[2];
    end
    if (en[1]) p1 <= ext_sbox(bi1[1], bi2[1], bi3[1]);
  end

  assign {bo1[0], bo2[0], bo3[0]} = p4[3];
  assign {bo1[1], bo2[1], bo3[1]} = p1;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic run_layer(
    input int d, input logic [63:0] a, input logic [63:0] b,
    input logic [63:0] c, input int lat, input bit retrig,
    output int start_abs, output int done_abs
  );
    int done_rel, ndone, inerr, enerr, berr;
    logic [3:0] e1, e2, e3;
    logic [63:0] x;
    done_rel = -1; done_abs = -1;
    ndone = 0; inerr = 0; enerr = 0; berr = 0;
    @(negedge clk);
    start[d] = 1'b1;
    si1[d] = a; si2[d] = b; si3[d] = c;
    @(posedge clk); #1;
    start[d] = 1'b0;
    start_abs = cyc_abs - 1;
    si1[d] = rnd64(); si2[d] = rnd64(); si3[d] = rnd64();
    for (int cy = 1; cy <= 18 + lat; cy++) begin
      if (cy > 1) begin
        @(posedge clk); #1;
      end
      start[d] = retrig && (cy == 5 || cy == 17 + lat);
      e1 = 4'h0; e2 = 4'h0; e3 = 4'h0;
      if (cy <= 16) begin
        e1 = a[4*(cy-1) +: 4];
        e2 = b[4*(cy-1) +: 4];
        e3 = c[4*(cy-1) +: 4];
      end
      if ({bi1[d], bi2[d], bi3[d]} !== {e1, e2, e3}) inerr++;
      if (en[d] !== (cy <= 15 + lat)) enerr++;
      if (cy != 17 + lat && busy[d] !== (cy < 17 + lat)) berr++;
      if (done[d] === 1'b1) begin
        ndone++;
        if (done_rel < 0) begin
          done_rel = cy;
          done_abs = cyc_abs;
        end
      end
    end
    start[d] = 1'b0;
    x = a ^ b ^ c;
    check("done_lat", 64'(done_rel), 64'(17 + lat));
    check("done_cnt", 64'(ndone), 64'd1);
    check("sbox_in", 64'(inerr), 64'd0);
    check("sbox_en", 64'(enerr), 64'd0);
    check("busy", 64'(berr), 64'd0);
    check("share1", so1[d], a);
    check("share2", so2[d], b);
    check("share3", so3[d], slayer(x) ^ a ^ b);
    check("unmasked", so1[d] ^ so2[d] ^ so3[d], slayer(x));
  endtask

  initial begin
    int s1, d1, s2, d2, nd;
    logic [63:0] a, b, xs;

    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0;
      si1[d] = rnd64(); si2[d] = rnd64(); si3[d] = rnd64();
    end

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_ctrl", {61'd0, busy[d], done[d], en[d]}, 64'd0);
      check("rst_sbin", {52'd0, bi1[d], bi2[d], bi3[d]}, 64'd0);
      check("rst_out", so1[d] | so2[d] | so3[d], 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    xs = 64'h0123456789ABCDEF;
    a = rnd64(); b = rnd64();
    run_layer(0, a, b, xs ^ a ^ b, 4, 1'b0, s1, d1);
    check("t1_layer", so1[0] ^ so2[0] ^ so3[0], slayer(xs));

    run_layer(0, 64'h0, 64'h0, 64'h0, 4, 1'b0, s1, d1);
    check("t2_cc", so1[0] ^ so2[0] ^ so3[0], {16{4'hC}});

    run_layer(0, rnd64(), rnd64(), rnd64(), 4, 1'b1, s1, d1);
    run_layer(0, rnd64(), rnd64(), rnd64(), 4, 1'b0, s2, d2);
    check("t3_start", 64'(s2 - s1), 64'd22);
    check("t3_done", 64'(d2 - s1), 64'd43);

    @(negedge clk);
    start[0] = 1'b1;
    si1[0] = rnd64(); si2[0] = rnd64(); si3[0] = rnd64();
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("t4_ctrl", {62'd0, busy[0], en[0]}, 64'd0);
    check("t4_out", so1[0] | so2[0] | so3[0], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done[0] === 1'b1) nd++;
    end
    check("t4_nodone", 64'(nd), 64'd0);
    a = rnd64(); b = rnd64();
    run_layer(0, a, b, xs ^ a ^ b, 4, 1'b0, s1, d1);

    for (int r = 0; r < 50; r++) begin
      run_layer(1, rnd64(), rnd64(), rnd64(), 1, 1'b0, s1, d1);
    end

    for (int r = 0; r < 1000; r++) begin
      run_layer(0, rnd64(), rnd64(), rnd64(), 4, 1'b0, s1, d1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
